// File: rtl/dcf_encoder.sv
// DCF77-style pulse-width time-code generator with a free-running local clock.
// Optional date fields (day, weekday, month, year) are built in when DCF_DATE_EN is defined.
module dcf_encoder #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       set_time,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
`ifdef DCF_DATE_EN
    input  logic [5:0] set_day,
    input  logic [2:0] set_wday,
    input  logic [4:0] set_month,
    input  logic [6:0] set_year,
`endif
    output logic       dcf_out,
    output logic [5:0] second,
    output logic       frame_start
);

    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef struct packed {
`ifdef DCF_DATE_EN
        logic [6:0] year;
        logic [4:0] month;
        logic [5:0] day;
        logic [2:0] wday;
`endif
        logic [4:0] hour;
        logic [5:0] min;
    } tod_t;

    // Advance one minute; the date rolls with a fixed 31-day month.
    function automatic tod_t tod_inc(input tod_t t);
        tod_t r;
        r = t;
        if (t.min == 6'd59) begin
            r.min = 6'd0;
            if (t.hour == 5'd23) begin
                r.hour = 5'd0;
`ifdef DCF_DATE_EN
                r.wday = (t.wday >= 3'd7) ? 3'd1 : t.wday + 3'd1;
                if (t.day >= 6'd31) begin
                    r.day = 6'd1;
                    if (t.month >= 5'd12) begin
                        r.month = 5'd1;
                        r.year  = (t.year >= 7'd99) ? 7'd0 : t.year + 7'd1;
                    end else begin
                        r.month = t.month + 5'd1;
                    end
                end else begin
                    r.day = t.day + 6'd1;
                end
`endif
            end else begin
                r.hour = t.hour + 5'd1;
            end
        end else begin
            r.min = t.min + 6'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    cent_q, cent_d;
    logic [5:0]    sec_q, sec_d;
    logic          run_q, run_d;
    logic          dcf_q, dcf_d;
    logic          fs_q, fs_d;
    tod_t          cur_q, cur_d;
    tod_t          snap_q, snap_d;

    logic          strobe;
    logic          frame_begin;
    logic          load_ok;
    tod_t          load_val;
    logic [63:0]   frame_bits;
    logic [7:0]    min_bcd;
    logic [7:0]    hour_bcd;
`ifdef DCF_DATE_EN
    logic [7:0]    day_bcd;
    logic [7:0]    month_bcd;
    logic [7:0]    year_bcd;
`endif

    assign strobe = (presc_q == PW'(DIV - 1));

    always_comb begin
        load_ok = set_time && (set_hour <= 8'd23) && (set_min <= 8'd59)
`ifdef DCF_DATE_EN
            && (set_day >= 6'd1) && (set_day <= 6'd31) && (set_wday >= 3'd1)
            && (set_month >= 5'd1) && (set_month <= 5'd12) && (set_year <= 7'd99)
`endif
            ;
        load_val      = '0;
        load_val.hour = set_hour[4:0];
        load_val.min  = set_min[5:0];
`ifdef DCF_DATE_EN
        load_val.day   = set_day;
        load_val.wday  = set_wday;
        load_val.month = set_month;
        load_val.year  = set_year;
`endif
    end

    // Frame bit vector, indexed by second, built from the frame snapshot.
    always_comb begin
        min_bcd            = to_bcd(7'(snap_q.min));
        hour_bcd           = to_bcd(7'(snap_q.hour));
        frame_bits         = '0;
        frame_bits[20]     = 1'b1;
        frame_bits[27:21]  = min_bcd[6:0];
        frame_bits[28]     = ^min_bcd;
        frame_bits[34:29]  = hour_bcd[5:0];
        frame_bits[35]     = ^hour_bcd;
`ifdef DCF_DATE_EN
        day_bcd            = to_bcd(7'(snap_q.day));
        month_bcd          = to_bcd(7'(snap_q.month));
        year_bcd           = to_bcd(snap_q.year);
        frame_bits[41:36]  = day_bcd[5:0];
        frame_bits[44:42]  = snap_q.wday;
        frame_bits[49:45]  = month_bcd[4:0];
        frame_bits[57:50]  = year_bcd;
        frame_bits[58]     = ^{day_bcd, snap_q.wday, month_bcd, year_bcd};
`endif
    end

    always_comb begin
        presc_d     = strobe ? '0 : presc_q + 1'b1;
        cent_d      = cent_q;
        sec_d       = sec_q;
        run_d       = run_q;
        snap_d      = snap_q;
        cur_d       = cur_q;
        fs_d        = 1'b0;
        frame_begin = 1'b0;

        // The first strobe after reset opens second 0 without advancing.
        if (strobe) begin
            if (!run_q) begin
                run_d       = 1'b1;
                frame_begin = 1'b1;
            end else if (cent_q == 7'd99) begin
                cent_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d       = 6'd0;
                    frame_begin = 1'b1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                cent_d = cent_q + 7'd1;
            end
        end

        if (frame_begin) begin
            snap_d = load_ok ? load_val : cur_q;
            cur_d  = tod_inc(snap_d);
            fs_d   = 1'b1;
        end else if (load_ok) begin
            cur_d = load_val;
        end

        dcf_d = run_q && (sec_q != 6'd59)
             && (cent_q < (frame_bits[sec_q] ? 7'd20 : 7'd10));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q <= '0;
            cent_q  <= '0;
            sec_q   <= '0;
            run_q   <= 1'b0;
            dcf_q   <= 1'b0;
            fs_q    <= 1'b0;
            cur_q   <= '0;
            snap_q  <= '0;
        end else begin
            presc_q <= presc_d;
            cent_q  <= cent_d;
            sec_q   <= sec_d;
            run_q   <= run_d;
            dcf_q   <= dcf_d;
            fs_q    <= fs_d;
            cur_q   <= cur_d;
            snap_q  <= snap_d;
        end
    end

    assign dcf_out     = dcf_q;
    assign second      = sec_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_dcf_encoder.sv
// Bench for dcf_encoder at CLK_HZ=100: records pulse widths per second and
// compares them with frames computed from a behavioural hour/minute model.
module tb_dcf_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_time = 1'b0;
    logic [7:0] set_hour = 8'd0;
    logic [7:0] set_min = 8'd0;
    logic       dcf_out;
    logic       frame_start;
    logic [5:0] second;

    int total = 0;
    int bad = 0;
    int widths[60];
    int gap, sec_err, fs_extra, wait_cycles;
    int m_hour = 0, m_min = 0;
    int exp_h = 0, exp_m = 0;

    always #5 clk = ~clk;

    dcf_encoder #(.CLK_HZ(100)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .set_time   (set_time),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .dcf_out    (dcf_out),
        .second     (second),
        .frame_start(frame_start)
    );

    // Expected pulse width (cycles) of second k in a frame carrying h:m.
    function automatic int exp_width(input int h, input int m, input int k);
        int bits[60];
        int p;
        for (int i = 0; i < 60; i++) bits[i] = 0;
        bits[20] = 1;
        for (int i = 0; i < 4; i++) bits[21 + i] = ((m % 10) >> i) & 1;
        for (int i = 0; i < 3; i++) bits[25 + i] = ((m / 10) >> i) & 1;
        for (int i = 0; i < 4; i++) bits[29 + i] = ((h % 10) >> i) & 1;
        for (int i = 0; i < 2; i++) bits[33 + i] = ((h / 10) >> i) & 1;
        p = 0;
        for (int i = 21; i <= 27; i++) p += bits[i];
        bits[28] = p % 2;
        p = 0;
        for (int i = 29; i <= 34; i++) p += bits[i];
        bits[35] = p % 2;
        if (k == 59) return 0;
        return (bits[k] != 0) ? 20 : 10;
    endfunction

    task automatic model_tick();
        m_min++;
        if (m_min == 60) begin
            m_min = 0;
            m_hour = (m_hour + 1) % 24;
        end
    endtask

    // Waits for frame_start, then samples one whole frame; optional load at sample load_j.
    task automatic capture_frame(input int load_j, input int lh, input int lm);
        int n, run;
        n = 0;
        while (frame_start !== 1'b1 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        wait_cycles = n;
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_start_wait: got no frame_start after %0d cycles, required one", n);
            return;
        end
        exp_h = m_hour;
        exp_m = m_min;
        model_tick();
        for (int k = 0; k < 60; k++) widths[k] = 0;
        sec_err = 0;
        fs_extra = 0;
        run = 0;
        for (int j = 0; j < 6000; j++) begin
            @(negedge clk);
            set_time = 1'b0;
            if (dcf_out === 1'b1) begin
                widths[j / 100]++;
                run = 0;
            end else begin
                run++;
            end
            if (second !== 6'(((j + 1) / 100) % 60)) sec_err++;
            if (j < 5999 && frame_start !== 1'b0) fs_extra++;
            if (j == load_j) begin
                set_time = 1'b1;
                set_hour = 8'(lh);
                set_min  = 8'(lm);
                if (lh <= 23 && lm <= 59) begin
                    m_hour = lh;
                    m_min  = lm;
                end
            end
        end
        gap = run;
        $display("frame %02d:%02d  w20=%0d w28=%0d w35=%0d gap=%0d", exp_h, exp_m,
                 widths[20], widths[28], widths[35], gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_time = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dcf_out !== 1'b0) begin bad++; $display("FAIL reset_dcf_out: got %b want 0", dcf_out); end
        total++;
        if (second !== 6'd0) begin bad++; $display("FAIL reset_second: got %0d want 0", second); end
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        rst = 1'b0;
        m_hour = 0;
        m_min = 0;
        capture_frame(-1, 0, 0);
        total++;
        if (wait_cycles > 2) begin bad++; $display("FAIL reset_first_strobe: frame_start after %0d cycles, want <=2", wait_cycles); end
        total++;
        if (widths[0] != 10) begin bad++; $display("FAIL reset_bit0: got %0d want 10", widths[0]); end
        total++;
        if (widths[20] != 20) begin bad++; $display("FAIL reset_bit20: got %0d want 20", widths[20]); end
        for (int k = 0; k < 60; k++) begin
            total++;
            if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                bad++;
                $display("FAIL reset_width sec=%0d got=%0d want=%0d", k, widths[k], exp_width(exp_h, exp_m, k));
            end
        end
        total++;
        if (sec_err != 0) begin bad++; $display("FAIL second_count: %0d wrong samples, want 0", sec_err); end
        total++;
        if (fs_extra != 0) begin bad++; $display("FAIL frame_start_once: %0d extra pulses, want 0", fs_extra); end
    endtask

    task automatic test_set_time();
        // Load at second 10; the frame in progress keeps its snapshot.
        for (int f = 0; f < 3; f++) begin
            if (f == 0) capture_frame(1000, 12, 34);
            else capture_frame(-1, 0, 0);
            for (int k = 0; k < 60; k++) begin
                total++;
                if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                    bad++;
                    $display("FAIL set_time_width f=%0d sec=%0d got=%0d want=%0d (%0d:%0d)", f, k,
                             widths[k], exp_width(exp_h, exp_m, k), exp_h, exp_m);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 3; f++) begin
            if (f == 0) capture_frame($urandom_range(0, 5997), 23, 59);
            else if (f == 2) capture_frame($urandom_range(0, 5998), 24, $urandom_range(0, 59));
            else capture_frame(-1, 0, 0);
            for (int k = 0; k < 60; k++) begin
                total++;
                if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                    bad++;
                    $display("FAIL wrap_width f=%0d sec=%0d got=%0d want=%0d (%0d:%0d)", f, k,
                             widths[k], exp_width(exp_h, exp_m, k), exp_h, exp_m);
                end
            end
        end
        for (int k = 21; k <= 35; k++) begin
            total++;
            if (widths[k] != 10) begin bad++; $display("FAIL midnight_bits sec=%0d got=%0d want=10", k, widths[k]); end
        end
        total++;
        if (gap < 180) begin bad++; $display("FAIL minute_gap: got %0d low cycles, want >=180", gap); end
    endtask

    task automatic test_back_to_back();
        // Loads landing exactly on the snapshot cycle: invalid then valid.
        for (int f = 0; f < 2; f++) begin
            if (f == 0) capture_frame(5998, $urandom_range(0, 23), 60);
            else capture_frame(5998, $urandom_range(0, 23), $urandom_range(0, 59));
            for (int k = 0; k < 60; k++) begin
                total++;
                if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                    bad++;
                    $display("FAIL b2b_width f=%0d sec=%0d got=%0d want=%0d (%0d:%0d)", f, k,
                             widths[k], exp_width(exp_h, exp_m, k), exp_h, exp_m);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL mid_wait: no frame_start after %0d cycles", n); end
        repeat (3005) @(negedge clk);
        total++;
        if (dcf_out !== 1'b1) begin bad++; $display("FAIL mid_pulse: got %b want 1 before reset", dcf_out); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (dcf_out !== 1'b0) begin bad++; $display("FAIL mid_dcf_out: got %b want 0", dcf_out); end
        total++;
        if (second !== 6'd0) begin bad++; $display("FAIL mid_second: got %0d want 0", second); end
        rst = 1'b0;
        m_hour = 0;
        m_min = 0;
        capture_frame(-1, 0, 0);
        for (int k = 0; k < 60; k++) begin
            total++;
            if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                bad++;
                $display("FAIL mid_width sec=%0d got=%0d want=%0d", k, widths[k], exp_width(exp_h, exp_m, k));
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) capture_frame($urandom_range(0, 5998), $urandom_range(0, 25), $urandom_range(0, 61));
            else capture_frame(-1, 0, 0);
            for (int k = 0; k < 60; k++) begin
                total++;
                if (widths[k] != exp_width(exp_h, exp_m, k)) begin
                    bad++;
                    $display("FAIL random_width f=%0d sec=%0d got=%0d want=%0d (%0d:%0d)", f, k,
                             widths[k], exp_width(exp_h, exp_m, k), exp_h, exp_m);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
